ahb2_dma_copy: RTL and testbench

AHB2_DMA_COPY -- requirements
Module: ahb2_dma_copy

---
 rtl/ahb2_pkg.sv | 17 +
 rtl/ahb2_dma_copy.sv | 170 +++++++++++++++++
 tb/tb_ahb2_dma_copy.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb2_pkg.sv
// Shared AHB2 encodings and small helpers for the AHB2 masters and slaves.
package ahb2_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0]  HRESP_OKAY    = 2'b00;
    localparam logic [1:0]  HRESP_ERROR   = 2'b01;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [31:0] ADDR_STEP     = 32'd4;

    // Byte address rounded down to its 32-bit word.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ahb2_dma_copy.sv
// Single-channel AHB2 word copier: one SINGLE read then one SINGLE write per word,
// never pipelining two transfers, with a sticky error flag and a done pulse.
module ahb2_dma_copy
    import ahb2_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           htrans,
    output logic [31:0]          haddr,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    output logic [31:0]          hwdata,
    input  logic [31:0]          hrdata,
    input  logic                 hready,
    input  logic [1:0]           hresp
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WDATA = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_count;
    logic [31:0]          r_buf;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [1:0]           r_htrans;
    logic [31:0]          r_haddr;
    logic                 r_hwrite;
    logic [31:0]          r_hwdata;

    wire w_len_zero  = (len == {LEN_WIDTH{1'b0}});
    wire w_last_word = (r_count == {{(LEN_WIDTH-1){1'b0}}, 1'b1});
    wire w_resp_err  = (hresp == HRESP_ERROR);

    // Copy sequencer; bus outputs are registered alongside the state they belong to,
    // so they stay frozen while the slave holds hready low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_src    <= 32'd0;
            r_dst    <= 32'd0;
            r_count  <= {LEN_WIDTH{1'b0}};
            r_buf    <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_htrans <= HTRANS_IDLE;
            r_haddr  <= 32'd0;
            r_hwrite <= 1'b0;
            r_hwdata <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_err  <= 1'b0;
                        if (w_len_zero) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_src    <= word_align(src_addr);
                            r_dst    <= word_align(dst_addr);
                            r_count  <= len;
                            r_state  <= ST_RADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= word_align(src_addr);
                            r_hwrite <= 1'b0;
                        end
                    end
                end
                ST_RADDR: begin
                    if (hready) begin
                        r_state  <= ST_RDATA;
                        r_htrans <= HTRANS_IDLE;
                    end
                end
                ST_RDATA: begin
                    if (hready) begin
                        if (w_resp_err) begin
                            // Buffer left untouched: the read data is not valid.
                            r_err   <= 1'b1;
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_buf    <= hrdata;
                            r_state  <= ST_WADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_haddr  <= r_dst;
                            r_hwrite <= 1'b1;
                        end
                    end
                end
                ST_WADDR: begin
                    if (hready) begin
                        r_state  <= ST_WDATA;
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_buf;
                    end
                end
                ST_WDATA: begin
                    if (hready) begin
                        if (w_resp_err) begin
                            r_err    <= 1'b1;
                            r_state  <= ST_FIN;
                            r_done   <= 1'b1;
                            r_hwrite <= 1'b0;
                        end else begin
                            r_src   <= r_src + ADDR_STEP;
                            r_dst   <= r_dst + ADDR_STEP;
                            r_count <= r_count - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                            if (w_last_word) begin
                                r_state  <= ST_FIN;
                                r_done   <= 1'b1;
                                r_hwrite <= 1'b0;
                            end else begin
                                r_state  <= ST_RADDR;
                                r_htrans <= HTRANS_NONSEQ;
                                r_haddr  <= r_src + ADDR_STEP;
                                r_hwrite <= 1'b0;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    // A start arriving here is dropped: the channel is still finishing.
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_htrans <= HTRANS_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_htrans <= HTRANS_IDLE;
                    r_hwrite <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign htrans = r_htrans;
    assign haddr  = r_haddr;
    assign hwrite = r_hwrite;
    assign hwdata = r_hwdata;
    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_SINGLE;

endmodule

// File: tb/tb_ahb2_dma_copy.sv
// Bench for ahb2_dma_copy: AHB2 memory slave with wait/error knobs, a transfer-plan
// model checked every cycle, and hand-computed literal expectations per scenario.
`timescale 1ns/1ps
module tb_ahb2_dma_copy;
    import ahb2_pkg::*;

    localparam int LW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic [31:0]   src_addr, dst_addr;
    logic [LW-1:0] len;
    logic          busy, done, err;
    logic [1:0]    htrans;
    logic [31:0]   haddr;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [31:0]   hwdata, hrdata;
    logic          hready;
    logic [1:0]    hresp;

    ahb2_dma_copy #(.LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- AHB2 memory slave (256 words, address bits [9:2]) ----------------
    logic [31:0] mem [0:255];
    logic        preload_req;
    int          rd_waits, wr_waits, astall, err_read_num;
    logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0;
    logic [7:0]  dp_idx = 8'd0;
    int          dp_wait = 0, astall_cnt = 0, rd_count = 0;

    assign hready = dp_valid ? (dp_wait == 0) : !((htrans == HTRANS_NONSEQ) && (astall_cnt > 0));
    assign hresp  = (dp_valid && dp_err) ? HRESP_ERROR : HRESP_OKAY;
    assign hrdata = (dp_valid && !dp_write && !dp_err) ? mem[dp_idx] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
        end
        if (rst) begin
            dp_valid   <= 1'b0;
            dp_err     <= 1'b0;
            dp_wait    <= 0;
            astall_cnt <= astall;
            rd_count   <= 0;
        end else begin
            if (start && !busy) rd_count <= 0;
            if (dp_valid) begin
                if (dp_wait != 0) dp_wait <= dp_wait - 1;
                else begin
                    if (dp_write && !dp_err) mem[dp_idx] <= hwdata;
                    dp_valid <= 1'b0;
                end
            end
            if (htrans == HTRANS_NONSEQ) begin
                if (hready) begin
                    dp_valid   <= 1'b1;
                    dp_write   <= hwrite;
                    dp_idx     <= haddr[9:2];
                    astall_cnt <= astall;
                    if (!hwrite) begin
                        rd_count <= rd_count + 1;
                        dp_err   <= (rd_count + 1 == err_read_num);
                        dp_wait  <= (rd_count + 1 == err_read_num) ? 1 : rd_waits;
                    end else begin
                        dp_err  <= 1'b0;
                        dp_wait <= wr_waits;
                    end
                end else if (!dp_valid) begin
                    astall_cnt <= astall_cnt - 1;
                end
            end else begin
                astall_cnt <= astall;
            end
        end
    end

    // ---------------- Model: planned transfer list and timing ----------------
    logic [31:0] exp_addr [0:31];
    logic        exp_wr   [0:31];
    logic [31:0] exp_dat  [0:31];
    int          exp_n = 0, run_id = 0, plan_cycles = 0;
    logic        plan_err = 1'b0;
    logic        check_en = 1'b0, m_active = 1'b0;
    int          m_start = 0, m_done = 0;
    logic        m_err_prev = 1'b0, m_err_final = 1'b0;

    // Words are copied in order; each transfer costs its address phase (plus stalls)
    // and its data phase (plus waits); an erroring read ends the copy.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int n, input int err_rd);
        logic [31:0] a_s, a_d;
        int k;
        a_s = s & 32'hFFFF_FFFC;
        a_d = d & 32'hFFFF_FFFC;
        k = 0;
        plan_cycles = 0;
        plan_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_addr[k] = a_s; exp_wr[k] = 1'b0; exp_dat[k] = 32'd0; k++;
            if (i + 1 == err_rd) begin
                plan_cycles += 1 + astall + 2;
                plan_err = 1'b1;
                break;
            end
            plan_cycles += 2 + astall + rd_waits;
            exp_addr[k] = a_d; exp_wr[k] = 1'b1; exp_dat[k] = mem[a_s[9:2]]; k++;
            plan_cycles += 2 + astall + wr_waits;
            a_s = a_s + 32'd4;
            a_d = a_d + 32'd4;
        end
        exp_n = k;
    endtask

    // ---------------- Per-cycle compare ----------------
    int   rd_ptr = 0, last_run = 0;
    logic cur_valid = 1'b0, cur_write = 1'b0;
    logic [31:0] cur_data = 32'd0;

    always @(negedge clk) begin
        int   p;
        logic cv, eb, ed, ee;
        if (rst || !check_en) begin
            cur_valid <= 1'b0;
            rd_ptr    <= exp_n;
            last_run  <= run_id;
        end else begin
            p  = (run_id != last_run) ? 0 : rd_ptr;
            cv = (run_id != last_run) ? 1'b0 : cur_valid;
            last_run <= run_id;
            rd_ptr   <= p;
            chk("hsize", {29'd0, hsize}, {29'd0, HSIZE_WORD});
            chk("hburst", {29'd0, hburst}, {29'd0, HBURST_SINGLE});
            cur_valid <= cv;
            if (cv) begin
                if (cur_write) chk("hwdata", hwdata, cur_data);
                if (hready) cur_valid <= 1'b0;
            end
            if (htrans == HTRANS_NONSEQ) begin
                chk("nonseq_planned", {31'd0, p < exp_n}, 32'd1);
                if (p < exp_n) begin
                    chk("haddr", haddr, exp_addr[p]);
                    chk("hwrite", {31'd0, hwrite}, {31'd0, exp_wr[p]});
                    if (hready) begin
                        cur_valid <= 1'b1;
                        cur_write <= exp_wr[p];
                        cur_data  <= exp_dat[p];
                        rd_ptr    <= p + 1;
                    end
                end
            end else begin
                chk("htrans_idle", {30'd0, htrans}, {30'd0, HTRANS_IDLE});
            end
            if (!m_active) begin
                eb = 1'b0; ed = 1'b0; ee = m_err_prev;
            end else begin
                eb = (cyc > m_start) && (cyc <= m_done);
                ed = (cyc == m_done);
                ee = (cyc <= m_start) ? m_err_prev : ((cyc < m_done) ? 1'b0 : m_err_final);
            end
            chk("busy", {31'd0, busy}, {31'd0, eb});
            chk("done", {31'd0, done}, {31'd0, ed});
            chk("err", {31'd0, err}, {31'd0, ee});
        end
    end

    // ---------------- Directed scenarios ----------------
    task automatic begin_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                              input int err_rd, output int st);
        plan(s, d, n, err_rd);
        @(posedge clk); #1;
        st          = cyc;
        m_err_prev  = m_active ? m_err_final : m_err_prev;
        m_err_final = plan_err;
        m_start     = st;
        m_done      = st + 1 + plan_cycles;
        m_active    = 1'b1;
        run_id      = run_id + 1;
        src_addr    = s;
        dst_addr    = d;
        len         = LW'(n);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int err_rd, input int lit_delta, input bit coin);
        int st, waited;
        begin_copy(s, d, n, err_rd, st);
        waited = 0;
        while (!done && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({nm, "_done_cycle"}, 32'(cyc - st), 32'(lit_delta));
        if (coin) begin
            src_addr = 32'h0;
            dst_addr = 32'h200;
            len      = LW'(5);
            start    = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({nm, "_transfers"}, 32'(rd_ptr), 32'(exp_n));
    endtask

    initial begin
        int st;
        rst = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = '0;
        preload_req = 1'b1;
        rd_waits = 0; wr_waits = 0; astall = 0; err_read_num = 0;
        repeat (3) @(posedge clk);
        #1;
        preload_req = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_htrans", {30'd0, htrans}, 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwrite", {31'd0, hwrite}, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        rst = 1'b0;
        check_en = 1'b1;

        // Four words, zero-wait slave.
        run_copy("basic", 32'h0, 32'h100, 4, 0, 17, 1'b0);
        for (int i = 0; i < 4; i++) chk("basic_mem", mem[8'h40 + 8'(i)], 32'(i));
        chk("basic_err", {31'd0, err}, 32'd0);

        // Three wait states on each read data phase.
        rd_waits = 3;
        run_copy("rdwait", 32'h20, 32'h180, 2, 0, 15, 1'b0);
        chk("rdwait_mem0", mem[8'h60], 32'h8);
        chk("rdwait_mem1", mem[8'h61], 32'h9);

        // Waits on every data phase plus address-phase stalls.
        wr_waits = 3; astall = 2;
        run_copy("allwait", 32'h28, 32'h1A0, 2, 0, 29, 1'b0);
        chk("allwait_mem0", mem[8'h68], 32'hA);
        chk("allwait_mem1", mem[8'h69], 32'hB);
        rd_waits = 0; wr_waits = 0; astall = 0;

        // ERROR on the second read.
        err_read_num = 2;
        run_copy("rderr", 32'h10, 32'h200, 3, 2, 8, 1'b0);
        chk("rderr_err", {31'd0, err}, 32'd1);
        chk("rderr_mem0", mem[8'h80], 32'h4);
        chk("rderr_mem1", mem[8'h81], 32'h81);
        err_read_num = 0;

        // Zero length, with a second start offered in the done cycle.
        run_copy("len0", 32'h0, 32'h0, 0, 0, 1, 1'b1);
        chk("len0_err_cleared", {31'd0, err}, 32'd0);

        // Source address wraps past the top of the address space.
        run_copy("wrap", 32'hFFFF_FFFC, 32'h300, 2, 0, 9, 1'b0);
        chk("wrap_mem0", mem[8'hC0], 32'hFF);
        chk("wrap_mem1", mem[8'hC1], 32'h0);

        // Reset during the write address phase of word 2.
        begin_copy(32'h40, 32'h380, 3, 0, st);
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_waddr_htrans", {30'd0, htrans}, {30'd0, HTRANS_NONSEQ});
        chk("mid_waddr_hwrite", {31'd0, hwrite}, 32'd1);
        rst = 1'b1;
        m_active = 1'b0;
        m_err_prev = 1'b0;
        @(posedge clk); #1;
        chk("midrst_htrans", {30'd0, htrans}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        run_copy("after_rst", 32'h60, 32'h3C0, 1, 0, 5, 1'b0);
        chk("after_rst_mem", mem[8'hF0], 32'h18);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
